// File: rtl/instr_enc_loader.sv
// instr_enc_loader: encodes LA32 ADD.W/ADDI.W/LU12I.W/LD.W/ST.W/BNE requests into
// 32-bit words and streams them with auto-incrementing word addresses to the IM.
module instr_enc_loader #(
    parameter int          IM_AW     = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rj,
    input  logic [4:0]       in_rk,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IM_AW-1:0] out_addr,
    output logic [31:0]      out_instr,
    output logic [IM_AW:0]   emit_cnt,
    output logic             full,
    output logic             err,
    output logic [1:0]       err_code
);
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_ADDI  = 3'd1,
        OP_LU12I = 3'd2,
        OP_LD    = 3'd3,
        OP_ST    = 3'd4,
        OP_BNE   = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_RANGE   = 2'b01,
        ERR_ILLEGAL = 2'b10,
        ERR_FULL    = 2'b11
    } err_e;

    localparam logic [IM_AW-1:0] ADDR_BASE = BASE_ADDR[IM_AW-1:0];
    localparam logic [IM_AW-1:0] ADDR_LAST = '1;

    logic [31:0]      w_instr;
    logic             w_range_ok;
    logic             w_legal_op;
    logic             w_si12_ok;
    logic             w_boff_ok;
    err_e             w_err;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;
    logic             w_emit;

    logic             r_out_valid;
    logic [IM_AW-1:0] r_out_addr;
    logic [31:0]      r_out_instr;
    logic [IM_AW-1:0] r_next_addr;
    logic [IM_AW:0]   r_emit_cnt;
    logic             r_full;
    logic             r_err;
    logic [1:0]       r_err_code;

    // si12 fits when bits [31:11] are a pure sign extension; the branch offset likewise
    // needs [31:17] to be sign-only plus word alignment.
    assign w_si12_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign w_boff_ok = (in_imm[1:0] == 2'b00) &&
                       ((in_imm[31:17] == '0) || (in_imm[31:17] == '1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        w_instr    = '0;
        w_range_ok = 1'b1;
        w_legal_op = 1'b1;
        case (in_op)
            OP_ADD:   w_instr = 32'h0010_0000 | {17'd0, in_rk, in_rj, in_rd};
            OP_ADDI: begin
                w_instr    = 32'h0280_0000 | {10'd0, in_imm[11:0], in_rj, in_rd};
                w_range_ok = w_si12_ok;
            end
            OP_LU12I: begin
                w_instr    = 32'h1400_0000 | {7'd0, in_imm[31:12], in_rd};
                w_range_ok = (in_imm[11:0] == 12'd0);
            end
            OP_LD: begin
                w_instr    = 32'h2880_0000 | {10'd0, in_imm[11:0], in_rj, in_rd};
                w_range_ok = w_si12_ok;
            end
            OP_ST: begin
                w_instr    = 32'h2980_0000 | {10'd0, in_imm[11:0], in_rj, in_rd};
                w_range_ok = w_si12_ok;
            end
            OP_BNE: begin
                w_instr    = 32'h5C00_0000 | {6'd0, in_imm[17:2], in_rj, in_rd};
                w_range_ok = w_boff_ok;
            end
            default:  w_legal_op = 1'b0;
        endcase

        if (r_full)           w_err = ERR_FULL;
        else if (!w_legal_op) w_err = ERR_ILLEGAL;
        else if (!w_range_ok) w_err = ERR_RANGE;
        else                  w_err = ERR_NONE;
    end

    // Held low throughout reset so no request can be taken before rstn releases.
    assign in_ready = rstn && !clr && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && (w_err == ERR_NONE);
    assign w_drop   = w_accept && (w_err != ERR_NONE);
    assign w_emit   = r_out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= ADDR_BASE;
            r_out_instr <= '0;
            r_next_addr <= ADDR_BASE;
            r_emit_cnt  <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= ADDR_BASE;
            r_out_instr <= '0;
            r_next_addr <= ADDR_BASE;
            r_emit_cnt  <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            if (w_emit) begin
                r_emit_cnt <= r_emit_cnt + 1'b1;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= r_next_addr;
                r_out_instr <= w_instr;
                // The last IM slot saturates the counter instead of wrapping onto address 0.
                if (r_next_addr == ADDR_LAST) begin
                    r_full <= 1'b1;
                end else begin
                    r_next_addr <= r_next_addr + 1'b1;
                end
            end else if (w_emit) begin
                r_out_valid <= 1'b0;
            end

            if (w_drop) begin
                r_err      <= 1'b1;
                r_err_code <= w_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_instr = r_out_instr;
    assign emit_cnt  = r_emit_cnt;
    assign full      = r_full;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_instr_enc_loader.sv
// Bench for instr_enc_loader: directed scenarios from the encoding rules plus a randomized
// run scored against a field-arithmetic reference model; two instances cover IM_AW=10 and 2.
module tb_instr_enc_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, clr, in_valid, out_ready, sel;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rj, in_rk;
    logic [31:0] in_imm;

    logic        b_in_ready, b_out_valid, b_full, b_err;
    logic [9:0]  b_addr;
    logic [31:0] b_instr;
    logic [10:0] b_emit;
    logic [1:0]  b_code;

    logic        s_in_ready, s_out_valid, s_full, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_instr;
    logic [2:0]  s_emit;
    logic [1:0]  s_code;

    instr_enc_loader #(.IM_AW(10), .BASE_ADDR(0)) dut_big (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid && !sel), .in_ready(b_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk), .in_imm(in_imm),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_addr(b_addr), .out_instr(b_instr), .emit_cnt(b_emit),
        .full(b_full), .err(b_err), .err_code(b_code)
    );

    instr_enc_loader #(.IM_AW(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid && sel), .in_ready(s_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk), .in_imm(in_imm),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_addr(s_addr), .out_instr(s_instr), .emit_cnt(s_emit),
        .full(s_full), .err(s_err), .err_code(s_code)
    );

    logic        o_ready, o_valid, o_full, o_err;
    logic [9:0]  o_addr;
    logic [31:0] o_instr;
    logic [10:0] o_emit;
    logic [1:0]  o_code;

    assign o_ready = sel ? s_in_ready  : b_in_ready;
    assign o_valid = sel ? s_out_valid : b_out_valid;
    assign o_full  = sel ? s_full      : b_full;
    assign o_err   = sel ? s_err       : b_err;
    assign o_addr  = sel ? {8'd0, s_addr} : b_addr;
    assign o_instr = sel ? s_instr     : b_instr;
    assign o_emit  = sel ? {8'd0, s_emit} : b_emit;
    assign o_code  = sel ? s_code      : b_code;

    int total = 0;
    int bad   = 0;

    // Reference encoder: builds words by field arithmetic and judges ranges on signed values.
    function automatic void ref_encode(input bit [2:0] op, input bit [31:0] rd, input bit [31:0] rj,
                                       input bit [31:0] rk, input bit [31:0] imm,
                                       output bit [31:0] word, output bit [1:0] code);
        int si;
        si   = $signed(imm);
        code = 2'd0;
        word = 32'd0;
        case (op)
            3'd0: word = 32'h0010_0000 + rk * 1024 + rj * 32 + rd;
            3'd1, 3'd3, 3'd4: begin
                word = (op == 3'd1) ? 32'h0280_0000 : (op == 3'd3) ? 32'h2880_0000 : 32'h2980_0000;
                word = word + (imm % 4096) * 1024 + rj * 32 + rd;
                if (si < -2048 || si > 2047) code = 2'd1;
            end
            3'd2: begin
                word = 32'h1400_0000 + (imm / 4096) * 32 + rd;
                if (imm % 4096 != 0) code = 2'd1;
            end
            3'd5: begin
                word = 32'h5C00_0000 + ((imm / 4) % 65536) * 1024 + rj * 32 + rd;
                if (imm % 4 != 0 || si < -131072 || si > 131068) code = 2'd1;
            end
            default: code = 2'd2;
        endcase
    endfunction

    task automatic set_req(input bit [2:0] op, input bit [4:0] rd, input bit [4:0] rj,
                           input bit [4:0] rk, input bit [31:0] imm);
        in_op = op; in_rd = rd; in_rj = rj; in_rk = rk; in_imm = imm;
        in_valid = 1'b1;
    endtask

    // Holds a request until the selected DUT takes it; returns at posedge+1 after acceptance.
    task automatic send(input bit [2:0] op, input bit [4:0] rd, input bit [4:0] rj,
                        input bit [4:0] rk, input bit [31:0] imm);
        int n = 0;
        set_req(op, rd, rj, rk, imm);
        #1;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout in_ready=%b want=1 after %0d cycles", o_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rd = '0; in_rj = '0; in_rk = '0; in_imm = '0;
        #2;
        total++;
        if ({b_out_valid, b_instr, b_addr, b_emit, b_full, b_err, b_code, b_in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_big got v=%b i=%h a=%h e=%h f=%b er=%b c=%b r=%b want all 0",
                     b_out_valid, b_instr, b_addr, b_emit, b_full, b_err, b_code, b_in_ready);
        end
        total++;
        if ({s_out_valid, s_instr, s_addr, s_emit, s_full, s_err, s_code, s_in_ready} !== '0) begin
            bad++;
            $display("FAIL reset_small got v=%b i=%h a=%h e=%h f=%b er=%b c=%b r=%b want all 0",
                     s_out_valid, s_instr, s_addr, s_emit, s_full, s_err, s_code, s_in_ready);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release in_ready=%b want=1", o_ready);
        end
        idle();
    endtask

    task automatic test_add_addi();
        logic [42:0] got, want;
        sel = 1'b0; out_ready = 1'b1;
        do_clr();
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        got = {o_valid, o_addr, o_instr}; want = {1'b1, 10'd0, 32'h0010_0823};
        total++;
        if (got !== want) begin bad++; $display("FAIL add_word got=%h want=%h", got, want); end
        send(3'd1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        got = {o_valid, o_addr, o_instr}; want = {1'b1, 10'd1, 32'h02BF_FC01};
        total++;
        if (got !== want) begin bad++; $display("FAIL addi_word got=%h want=%h", got, want); end
        idle();
        total++;
        if ({o_valid, o_emit} !== {1'b0, 11'd2}) begin
            bad++; $display("FAIL add_emit got v=%b cnt=%0d want v=0 cnt=2", o_valid, o_emit);
        end
    endtask

    task automatic test_load_store();
        logic [42:0] got, want;
        sel = 1'b0; out_ready = 1'b1;
        do_clr();
        send(3'd2, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        got = {o_valid, o_addr, o_instr}; want = {1'b1, 10'd0, 32'h1424_68A5};
        total++;
        if (got !== want) begin bad++; $display("FAIL lu12i_word got=%h want=%h", got, want); end
        send(3'd3, 5'd2, 5'd1, 5'd0, 32'd4);
        got = {o_valid, o_addr, o_instr}; want = {1'b1, 10'd1, 32'h2880_1022};
        total++;
        if (got !== want) begin bad++; $display("FAIL ld_word got=%h want=%h", got, want); end
        send(3'd4, 5'd4, 5'd6, 5'd0, 32'd8);
        got = {o_valid, o_addr, o_instr}; want = {1'b1, 10'd2, 32'h2980_20C4};
        total++;
        if (got !== want) begin bad++; $display("FAIL st_word got=%h want=%h", got, want); end
        send(3'd5, 5'd2, 5'd1, 5'd0, 32'hFFFF_FFF8);
        got = {o_valid, o_addr, o_instr}; want = {1'b1, 10'd3, 32'h5FFF_F822};
        total++;
        if (got !== want) begin bad++; $display("FAIL bne_word got=%h want=%h", got, want); end
        send(3'd5, 5'd2, 5'd1, 5'd0, 32'd6);
        total++;
        if ({o_valid, o_err, o_code} !== {1'b0, 1'b1, 2'b01}) begin
            bad++; $display("FAIL bne_misalign got v=%b err=%b code=%b want v=0 err=1 code=01",
                            o_valid, o_err, o_code);
        end
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        got = {o_valid, o_addr, o_instr}; want = {1'b1, 10'd4, 32'h0010_0823};
        total++;
        if (got !== want) begin bad++; $display("FAIL after_drop_addr got=%h want=%h", got, want); end
        idle();
    endtask

    task automatic test_illegal();
        logic [42:0] got, want;
        sel = 1'b0; out_ready = 1'b1;
        do_clr();
        send(3'd1, 5'd1, 5'd0, 5'd0, 32'd2048);
        total++;
        if ({o_valid, o_err, o_code} !== {1'b0, 1'b1, 2'b01}) begin
            bad++; $display("FAIL addi_range got v=%b err=%b code=%b want v=0 err=1 code=01",
                            o_valid, o_err, o_code);
        end
        send(3'd7, 5'd1, 5'd0, 5'd0, 32'd0);
        total++;
        if ({o_valid, o_err, o_code} !== {1'b0, 1'b1, 2'b10}) begin
            bad++; $display("FAIL illegal_op got v=%b err=%b code=%b want v=0 err=1 code=10",
                            o_valid, o_err, o_code);
        end
        send(3'd1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        got = {o_valid, o_addr, o_instr}; want = {1'b1, 10'd0, 32'h02BF_FC01};
        total++;
        if (got !== want) begin bad++; $display("FAIL after_illegal got=%h want=%h", got, want); end
        idle();
    endtask

    task automatic test_back_pressure();
        logic [43:0] got, want;
        sel = 1'b0; out_ready = 1'b0;
        do_clr();
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            #1;
            got = {o_valid, o_addr, o_instr, o_ready}; want = {1'b1, 10'd0, 32'h0010_0823, 1'b0};
            total++;
            if (got !== want) begin bad++; $display("FAIL stall_%0d got=%h want=%h", i, got, want); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL stall_release in_ready=%b want=1", o_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if ({o_valid, o_addr, o_instr, o_emit} !== {1'b1, 10'd1, 32'h02BF_FC01, 11'd1}) begin
            bad++; $display("FAIL stall_next got v=%b a=%0d i=%h cnt=%0d want v=1 a=1 i=02bffc01 cnt=1",
                            o_valid, o_addr, o_instr, o_emit);
        end
        idle();
        total++;
        if ({o_valid, o_emit} !== {1'b0, 11'd2}) begin
            bad++; $display("FAIL stall_drain got v=%b cnt=%0d want v=0 cnt=2", o_valid, o_emit);
        end
    endtask

    task automatic test_full_small();
        sel = 1'b1; out_ready = 1'b1;
        do_clr();
        for (int i = 0; i < 4; i++) begin
            send(3'd0, 5'(i + 1), 5'd0, 5'd0, 32'd0);
            total++;
            if ({o_valid, o_addr, o_instr, o_full} !== {1'b1, 10'(i), 32'h0010_0000 + 32'(i + 1), (i == 3)}) begin
                bad++; $display("FAIL fill_%0d got v=%b a=%0d i=%h full=%b want a=%0d full=%b",
                                i, o_valid, o_addr, o_instr, o_full, i, (i == 3));
            end
        end
        send(3'd0, 5'd9, 5'd0, 5'd0, 32'd0);
        total++;
        if ({o_valid, o_full, o_err, o_code, o_emit} !== {1'b0, 1'b1, 1'b1, 2'b11, 11'd4}) begin
            bad++; $display("FAIL full_err got v=%b full=%b err=%b code=%b cnt=%0d want 0 1 1 11 4",
                            o_valid, o_full, o_err, o_code, o_emit);
        end
        set_req(3'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        clr = 1'b1;
        #1;
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL clr_ready in_ready=%b want=0", o_ready); end
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        total++;
        if ({o_valid, o_addr, o_emit, o_full, o_err, o_code} !== '0) begin
            bad++; $display("FAIL clr_state got v=%b a=%0d cnt=%0d full=%b err=%b code=%b want all 0",
                            o_valid, o_addr, o_emit, o_full, o_err, o_code);
        end
        out_ready = 1'b0;
        send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        idle();
        rstn = 1'b0;
        #1;
        total++;
        if ({o_valid, o_instr, o_addr, o_emit, o_full, o_err, o_code, o_ready} !== '0) begin
            bad++; $display("FAIL reset_mid got v=%b i=%h a=%0d cnt=%0d full=%b err=%b code=%b r=%b want all 0",
                            o_valid, o_instr, o_addr, o_emit, o_full, o_err, o_code, o_ready);
        end
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        idle();
    endtask

    task automatic rand_req();
        int imm_edge[12] = '{2047, 2048, -2048, -2049, 131068, 131072, -131072, -131076,
                             6, -8, 4096, 32'h1234_5001};
        in_op = 3'($urandom_range(0, 7));
        in_rd = 5'($urandom); in_rj = 5'($urandom); in_rk = 5'($urandom);
        case ($urandom_range(0, 4))
            0: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1: in_imm = imm_edge[$urandom_range(0, 11)];
            2: in_imm = $urandom;
            3: in_imm = $urandom & 32'hFFFF_F000;
            default: in_imm = 32'($urandom_range(0, 65535)) * 4 - 32'd131072;
        endcase
    endtask

    task automatic test_random(input bit which, input int cycles);
        bit [31:0] m_instr, w;
        bit [1:0]  m_code, c;
        bit        m_valid, m_full, m_err, exp_rdy;
        int        m_addr, m_next, m_emit, last;
        sel = which; out_ready = 1'b1; in_valid = 1'b0;
        do_clr();
        last = which ? 3 : 1023;
        m_valid = 0; m_full = 0; m_err = 0; m_code = 0; m_instr = 0;
        m_addr = 0; m_next = 0; m_emit = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            total++;
            if (o_valid !== m_valid || (m_valid && (o_addr !== m_addr[9:0] || o_instr !== m_instr))) begin
                bad++; $display("FAIL rnd%0d_word cyc=%0d got v=%b a=%0d i=%h want v=%b a=%0d i=%h",
                                which, cyc, o_valid, o_addr, o_instr, m_valid, m_addr, m_instr);
            end
            total++;
            if ({o_emit, o_full, o_err, o_code} !== {m_emit[10:0], m_full, m_err, m_code}) begin
                bad++; $display("FAIL rnd%0d_status cyc=%0d got cnt=%0d f=%b e=%b c=%b want cnt=%0d f=%b e=%b c=%b",
                                which, cyc, o_emit, o_full, o_err, o_code, m_emit, m_full, m_err, m_code);
            end
            clr       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_req();
            #1;
            exp_rdy = !clr && (!m_valid || out_ready);
            total++;
            if (o_ready !== exp_rdy) begin
                bad++; $display("FAIL rnd%0d_ready cyc=%0d got=%b want=%b", which, cyc, o_ready, exp_rdy);
            end
            if (clr) begin
                m_valid = 0; m_full = 0; m_err = 0; m_code = 0;
                m_addr = 0; m_next = 0; m_emit = 0;
            end else begin
                if (m_valid && out_ready) begin
                    m_emit++;
                    m_valid = 0;
                end
                if (in_valid && exp_rdy) begin
                    ref_encode(in_op, 32'(in_rd), 32'(in_rj), 32'(in_rk), in_imm, w, c);
                    if (m_full) c = 2'd3;
                    if (c == 2'd0) begin
                        m_valid = 1; m_instr = w; m_addr = m_next;
                        if (m_next == last) m_full = 1;
                        else m_next++;
                    end else begin
                        m_err = 1; m_code = c;
                    end
                end
            end
            @(posedge clk); #1;
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_addi();
        test_load_store();
        test_illegal();
        test_back_pressure();
        test_full_small();
        test_random(1'b0, 400);
        test_random(1'b1, 400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
